shm_port_responder: RTL and testbench

- Responder that owns one port of the shared dual_port_ram and serves a valid/ready request stream from a client (initiator) on the backward path.
- Accepts read/write requests, drives the RAM port, absorbs the RAM's 1-cycle synchronous read latency, and returns one in-order response per request through a 2-entry response buffer with full backpressure.

---
 rtl/shm_pkg.sv | 23 ++
 rtl/shm_rsp_fifo.sv | 54 +++++
 rtl/shm_port_responder.sv | 85 ++++++++
 tb/tb_shm_port_responder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shm_pkg.sv
// rtl/shm_pkg.sv - shared constants, response entry type and credit helper for the shm port responder
package shm_pkg;

  localparam int SHM_ADDR_WIDTH = 10;
  localparam int SHM_DATA_WIDTH = 32;
  localparam int SHM_CNT_WIDTH  = 16;
  localparam int RSP_DEPTH      = 2;
  localparam int RSP_CNT_WIDTH  = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic                      is_write;
    logic [SHM_DATA_WIDTH-1:0] rdata;
  } rsp_entry_t;

  // Buffered plus in-flight responses, less the one leaving this cycle, must leave a free slot.
  function automatic logic credit_ok(input logic [RSP_CNT_WIDTH-1:0] count,
                                     input logic infl_v, input logic pop);
    logic [RSP_CNT_WIDTH:0] occ;
    occ = {1'b0, count} + {{RSP_CNT_WIDTH{1'b0}}, infl_v} - {{RSP_CNT_WIDTH{1'b0}}, pop};
    return occ < (RSP_CNT_WIDTH + 1)'(RSP_DEPTH);
  endfunction

endpackage

// File: rtl/shm_rsp_fifo.sv
// rtl/shm_rsp_fifo.sv - first-word-fall-through response FIFO with occupancy count
module shm_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop    = pop && (count != '0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_next(wr_ptr);
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Upstream credit accounting must never let a push land on a full buffer.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && count == CNT_W'(DEPTH)));

endmodule

// File: rtl/shm_port_responder.sv
// rtl/shm_port_responder.sv - serves valid/ready read/write requests on one RAM port with in-order buffered responses
module shm_port_responder
  import shm_pkg::*;
#(
  parameter int ADDR_WIDTH = SHM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SHM_DATA_WIDTH,
  parameter int CNT_WIDTH  = SHM_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_is_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  logic                     acc;
  logic                     pop;
  logic                     infl_v;
  logic                     infl_we;
  logic [RSP_CNT_WIDTH-1:0] rsp_count;
  logic [DATA_WIDTH:0]      push_data;
  logic [DATA_WIDTH:0]      head_data;

  assign rsp_valid = (rsp_count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign req_ready = rst_n && credit_ok(rsp_count, infl_v, pop);
  assign acc       = req_valid && req_ready;

  assign ram_addr  = req_addr;
  assign ram_wdata = req_wdata;
  assign ram_we    = rst_n && acc && req_we;

  // S1: one-cycle slot covering the RAM's synchronous read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_v  <= 1'b0;
      infl_we <= 1'b0;
    end else begin
      infl_v <= acc;
      if (acc) infl_we <= req_we;
    end
  end

  // S2: capture RAM data (or a write ack) into the response buffer.
  assign push_data = {infl_we, infl_we ? {DATA_WIDTH{1'b0}} : ram_rdata};

  shm_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (infl_v),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (rsp_count)
  );

  assign rsp_is_write = rsp_valid && head_data[DATA_WIDTH];
  assign rsp_rdata    = rsp_valid ? head_data[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (acc && !req_we) rd_count <= rd_count + CNT_WIDTH'(1);
      if (acc && req_we)  wr_count <= wr_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_shm_port_responder.sv
// tb/tb_shm_port_responder.sv - directed table and sequence checks for shm_port_responder
module tb_shm_port_responder;
  import shm_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_is_write;
  logic [DW-1:0] rsp_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [CW-1:0] rd_count, wr_count;

  shm_port_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_write(rsp_is_write),
    .rsp_rdata(rsp_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_pop = 0;
  int n_rd_pop = 0;
  int n_acc = 0;
  int stalls = 0;
  bit chk_lat = 0;
  bit bp_done = 0;
  logic [DW-1:0] last_rdata = '0;
  logic [DW-1:0] ram    [1024];
  logic [DW-1:0] golden [1024];

  typedef struct {
    rsp_entry_t e;
    int         cyc;
  } exp_t;
  exp_t expq[$];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_w;
    logic [DW-1:0] exp_d;
    logic [CW-1:0] exp_rd;
    logic [CW-1:0] exp_wr;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Behavioural single-port synchronous RAM.
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected responses queued at accept, compared at pop.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      expq.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got is_write=%0d rdata=0x%0h, want none", rsp_is_write, rsp_rdata);
        end else begin
          e = expq.pop_front();
          check("rsp_is_write", 64'(rsp_is_write), 64'(e.e.is_write));
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.e.rdata));
          if (chk_lat) check("rsp_latency", 64'(cyc - e.cyc), 64'd2);
          if (!rsp_is_write) begin
            last_rdata = rsp_rdata;
            n_rd_pop++;
          end
          n_pop++;
        end
      end
      if (req_valid && req_ready) begin
        e.e.is_write = req_we;
        e.e.rdata    = req_we ? '0 : golden[req_addr];
        e.cyc        = cyc;
        expq.push_back(e);
        if (req_we) golden[req_addr] = req_wdata;
        n_acc++;
      end
    end
  end

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int waited = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      waited++;
      stalls++;
      if (waited > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: got no accept after %0d cycles, want accept", waited);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_rsp_timeout: got rsp_valid=0, want 1");
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (expq.size() == 0 && !rsp_valid) begin
        @(posedge clk); #1;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL drain_timeout: got %0d pending, want 0", expq.size());
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pop0, acc0, rd0;
    for (int i = 0; i < 1024; i++) begin
      ram[i]    = '0;
      golden[i] = '0;
    end
    tbl[0] = '{1'b1, 10'h03F, 32'hDEADBEEF, 1'b1, 32'h0,        16'd0, 16'd1};
    tbl[1] = '{1'b0, 10'h03F, 32'h0,        1'b0, 32'hDEADBEEF, 16'd1, 16'd1};
    tbl[2] = '{1'b1, 10'h100, 32'h11111111, 1'b1, 32'h0,        16'd1, 16'd2};
    tbl[3] = '{1'b0, 10'h100, 32'h0,        1'b0, 32'h11111111, 16'd2, 16'd2};
    tbl[4] = '{1'b1, 10'h3FF, 32'hA5A5A5A5, 1'b1, 32'h0,        16'd2, 16'd3};
    tbl[5] = '{1'b0, 10'h3FF, 32'h0,        1'b0, 32'hA5A5A5A5, 16'd3, 16'd3};
    tbl[6] = '{1'b0, 10'h000, 32'h0,        1'b0, 32'h0,        16'd4, 16'd3};
    tbl[7] = '{1'b1, 10'h000, 32'hFFFFFFFF, 1'b1, 32'h0,        16'd4, 16'd4};
    tbl[8] = '{1'b0, 10'h000, 32'h0,        1'b0, 32'hFFFFFFFF, 16'd5, 16'd4};

    // Reset state, with a write request pending to prove ram_we is held off.
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h055; req_wdata = 32'h1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_ram_we", 64'(ram_we), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_is_write", 64'(rsp_is_write), 64'd0);
    check("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("reset_rd_count", 64'(rd_count), 64'd0);
    check("reset_wr_count", 64'(wr_count), 64'd0);
    @(posedge clk); #1;
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      send(tbl[i].we, tbl[i].addr, tbl[i].wdata);
      idle();
      wait_rsp();
      check("tbl_is_write", 64'(rsp_is_write), 64'(tbl[i].exp_w));
      check("tbl_rdata", 64'(rsp_rdata), 64'(tbl[i].exp_d));
      @(posedge clk); #1;
      check("tbl_rd_count", 64'(rd_count), 64'(tbl[i].exp_rd));
      check("tbl_wr_count", 64'(wr_count), 64'(tbl[i].exp_wr));
    end

    // Read immediately after a write to the same address.
    send(1'b1, 10'h100, 32'h12345678);
    send(1'b0, 10'h100, 32'h0);
    idle();
    drain();
    check("raw_rdata", 64'(last_rdata), 64'h12345678);

    // Back-to-back stream at full rate.
    stalls = 0;
    rd0 = n_rd_pop;
    chk_lat = 1'b1;
    for (int i = 0; i < 16; i++) send(1'b1, AW'(i), DW'(i * 3));
    for (int i = 0; i < 16; i++) send(1'b0, AW'(i), 32'h0);
    idle();
    drain();
    chk_lat = 1'b0;
    check("stream_stalls", 64'(stalls), 64'd0);
    check("stream_read_rsps", 64'(n_rd_pop - rd0), 64'd16);
    check("stream_last_rdata", 64'(last_rdata), 64'd45);

    // Backpressure: only two requests fit while responses are held.
    rsp_ready = 1'b0;
    acc0 = n_acc;
    pop0 = n_pop;
    bp_done = 1'b0;
    fork
      begin
        send(1'b0, 10'h03F, 32'h0);
        send(1'b0, 10'h100, 32'h0);
        send(1'b0, 10'h3FF, 32'h0);
        send(1'b0, 10'h005, 32'h0);
        idle();
        bp_done = 1'b1;
      end
    join_none
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp_accepted_held", 64'(n_acc - acc0), 64'd2);
    check("bp_req_ready", 64'(req_ready), 64'd0);
    check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100 && !bp_done; i++) @(posedge clk);
    #1;
    check("bp_done", 64'(bp_done), 64'd1);
    drain();
    check("bp_accepted_all", 64'(n_acc - acc0), 64'd4);
    check("bp_pops", 64'(n_pop - pop0), 64'd4);
    check("bp_last_rdata", 64'(last_rdata), 64'd15);

    // Reset with one response buffered and one write in flight.
    rsp_ready = 1'b0;
    send(1'b0, 10'h03F, 32'h0);
    send(1'b1, 10'h200, 32'hCAFEF00D);
    check("pre_reset_rsp_valid", 64'(rsp_valid), 64'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h200; req_wdata = 32'h0BAD0BAD;
    rst_n = 1'b0;
    #1;
    check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_req_ready", 64'(req_ready), 64'd0);
    check("mid_ram_we", 64'(ram_we), 64'd0);
    check("mid_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("mid_rd_count", 64'(rd_count), 64'd0);
    check("mid_wr_count", 64'(wr_count), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    idle();
    pop0 = n_pop;
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_mid_no_rsp", 64'(n_pop - pop0), 64'd0);
    check("post_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    send(1'b0, 10'h200, 32'h0);
    idle();
    drain();
    check("committed_write", 64'(last_rdata), 64'hCAFEF00D);
    send(1'b0, 10'h03F, 32'h0);
    idle();
    drain();
    check("kept_data", 64'(last_rdata), 64'hDEADBEEF);
    check("post_mid_rd_count", 64'(rd_count), 64'd2);
    check("post_mid_wr_count", 64'(wr_count), 64'd0);

    // Write counter wrap.
    for (int i = 0; i < 65535; i++) send(1'b1, AW'(i), DW'(i));
    check("wr_count_max", 64'(wr_count), 64'hFFFF);
    send(1'b1, 10'h001, 32'h1);
    check("wr_count_wrap", 64'(wr_count), 64'h0);
    idle();
    drain();
    check("wrap_rd_count", 64'(rd_count), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
